rob_param: RTL and testbench

//   Parametrised reorder buffer: successor to the fixed 16-entry/4-dispatch/6-completion ROB.

---
 rtl/rob_param.sv | 159 +++++++++++++++
 tb/tb_rob_param.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer between rename/dispatch and the free list.
// Allocates up to DISPATCH_W entries per cycle in program order, accepts CMPL_W
// out-of-order completion tags, retires up to RETIRE_W done entries in order and
// returns their bundle and old physical register.
// Optional feature: define ROB_FLUSH_EN to add the i_flush input (flush all in-flight
// entries, tail snaps back to head).
module rob_param #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DISPATCH_W = 4,
    parameter int unsigned CMPL_W     = 6,
    parameter int unsigned RETIRE_W   = 4,
    parameter int unsigned BUNDLE_W   = 57,
    parameter int unsigned PREG_W     = 6
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
`ifdef ROB_FLUSH_EN
    input  logic                                i_flush,
`endif
    input  logic [$clog2(DISPATCH_W+1)-1:0]     i_ins_count,
    input  logic [DISPATCH_W*BUNDLE_W-1:0]      i_ins_bundle,
    input  logic [DISPATCH_W*PREG_W-1:0]        i_ins_old_p,
    output logic [$clog2(DEPTH)-1:0]            o_alloc_idx,
    output logic [$clog2(DEPTH):0]              o_free,
    output logic                                o_disp_err,
    input  logic [CMPL_W-1:0]                   i_cmpl_en,
    input  logic [CMPL_W*$clog2(DEPTH)-1:0]     i_cmpl,
    output logic [$clog2(RETIRE_W+1)-1:0]       o_ret_count,
    output logic [RETIRE_W*BUNDLE_W-1:0]        o_ret_bundle,
    output logic [RETIRE_W*PREG_W-1:0]          o_ret_old_p,
    output logic                                o_empty
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned PTR_W  = IDX_W + 1;
    localparam int unsigned RCNT_W = $clog2(RETIRE_W + 1);

    // head/tail carry a wrap bit above the index so full and empty are distinct
    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     done_q;
    logic [BUNDLE_W-1:0]  bundle_q [DEPTH];
    logic [PREG_W-1:0]    old_p_q  [DEPTH];

    logic [PTR_W-1:0]     used;
    logic [PTR_W-1:0]     free;
    logic                 flush;
    logic                 disp_ok;
    logic                 disp_go;
    logic [RCNT_W-1:0]    ret_n;
    logic [RCNT_W-1:0]    ret_go;
    logic                 run;
    logic [IDX_W-1:0]     ridx;
    logic [RETIRE_W*BUNDLE_W-1:0] ret_bundle_d;
    logic [RETIRE_W*PREG_W-1:0]   ret_old_p_d;

`ifdef ROB_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    // Occupancy is purely registered, so same-edge retirement never frees space
    // for same-edge dispatch.
    assign used        = tail_q - head_q;
    assign free        = PTR_W'(DEPTH) - used;
    assign o_free      = free;
    assign o_alloc_idx = tail_q[IDX_W-1:0];
    assign o_empty     = (head_q == tail_q);

    // Dispatch acceptance: whole group or nothing
    always_comb begin
        disp_ok = (32'(i_ins_count) <= DISPATCH_W) && (32'(i_ins_count) <= 32'(free));
        disp_go = disp_ok && !flush && (i_ins_count != '0);
    end

    // Count the in-order run of valid&done entries from head and gather their payloads
    always_comb begin
        ret_n        = '0;
        run          = 1'b1;
        ridx         = '0;
        ret_bundle_d = '0;
        ret_old_p_d  = '0;
        for (int unsigned k = 0; k < RETIRE_W; k++) begin
            ridx = head_q[IDX_W-1:0] + IDX_W'(k);
            if (run && valid_q[ridx] && done_q[ridx]) begin
                ret_n = RCNT_W'(k + 1);
                ret_bundle_d[k*BUNDLE_W +: BUNDLE_W] = bundle_q[ridx];
                ret_old_p_d[k*PREG_W +: PREG_W]      = old_p_q[ridx];
            end else begin
                run = 1'b0;
            end
        end
        ret_go = flush ? '0 : ret_n;
    end

    // Pointer, status-bit and retire-output state; flush overrides every other event
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q       <= '0;
            tail_q       <= '0;
            valid_q      <= '0;
            done_q       <= '0;
            o_disp_err   <= 1'b0;
            o_ret_count  <= '0;
            o_ret_bundle <= '0;
            o_ret_old_p  <= '0;
        end else if (flush) begin
            valid_q      <= '0;
            done_q       <= '0;
            tail_q       <= head_q;
            o_disp_err   <= 1'b0;
            o_ret_count  <= '0;
            o_ret_bundle <= '0;
            o_ret_old_p  <= '0;
        end else begin
            o_disp_err <= !disp_ok;
            if (disp_go) begin
                for (int unsigned k = 0; k < DISPATCH_W; k++) begin
                    if (k < 32'(i_ins_count)) begin
                        valid_q[tail_q[IDX_W-1:0] + IDX_W'(k)] <= 1'b1;
                        done_q[tail_q[IDX_W-1:0] + IDX_W'(k)]  <= 1'b0;
                    end
                end
                tail_q <= tail_q + PTR_W'(i_ins_count);
            end
            for (int unsigned p = 0; p < CMPL_W; p++) begin
                if (i_cmpl_en[p] && valid_q[i_cmpl[p*IDX_W +: IDX_W]]) begin
                    done_q[i_cmpl[p*IDX_W +: IDX_W]] <= 1'b1;
                end
            end
            // Retire clears come last so they win over a redundant completion of a retiring entry
            for (int unsigned k = 0; k < RETIRE_W; k++) begin
                if (k < 32'(ret_go)) begin
                    valid_q[head_q[IDX_W-1:0] + IDX_W'(k)] <= 1'b0;
                    done_q[head_q[IDX_W-1:0] + IDX_W'(k)]  <= 1'b0;
                end
            end
            head_q       <= head_q + PTR_W'(ret_go);
            o_ret_count  <= ret_go;
            o_ret_bundle <= ret_bundle_d;
            o_ret_old_p  <= ret_old_p_d;
        end
    end

    // Payload storage written on accepted dispatch; contents are qualified by valid_q
    always_ff @(posedge i_clk) begin
        if (disp_go) begin
            for (int unsigned k = 0; k < DISPATCH_W; k++) begin
                if (k < 32'(i_ins_count)) begin
                    bundle_q[tail_q[IDX_W-1:0] + IDX_W'(k)] <= i_ins_bundle[k*BUNDLE_W +: BUNDLE_W];
                    old_p_q[tail_q[IDX_W-1:0] + IDX_W'(k)]  <= i_ins_old_p[k*PREG_W +: PREG_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: directed bench for rob_param with a retirement scoreboard.
// Define ROB_FLUSH_EN to also exercise the flush path.
module tb_rob_param;

    logic          clk;
    logic          rst_n;
    logic          i_flush;
    logic [2:0]    i_ins_count;
    logic [227:0]  i_ins_bundle;
    logic [23:0]   i_ins_old_p;
    logic [3:0]    o_alloc_idx;
    logic [4:0]    o_free;
    logic          o_disp_err;
    logic [5:0]    i_cmpl_en;
    logic [23:0]   i_cmpl;
    logic [2:0]    o_ret_count;
    logic [227:0]  o_ret_bundle;
    logic [23:0]   o_ret_old_p;
    logic          o_empty;

    typedef struct packed {
        logic [56:0] b;
        logic [5:0]  p;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   oid    = 1;
    int   tail_m = 0;
    int   head_m = 0;

    rob_param #(
        .DEPTH(16), .DISPATCH_W(4), .CMPL_W(6), .RETIRE_W(4), .BUNDLE_W(57), .PREG_W(6)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
`ifdef ROB_FLUSH_EN
        .i_flush(i_flush),
`endif
        .i_ins_count(i_ins_count),
        .i_ins_bundle(i_ins_bundle),
        .i_ins_old_p(i_ins_old_p),
        .o_alloc_idx(o_alloc_idx),
        .o_free(o_free),
        .o_disp_err(o_disp_err),
        .i_cmpl_en(i_cmpl_en),
        .i_cmpl(i_cmpl),
        .o_ret_count(o_ret_count),
        .o_ret_bundle(o_ret_bundle),
        .o_ret_old_p(o_ret_old_p),
        .o_empty(o_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [56:0] bfun(input logic [5:0] p);
        return {p, 3'b101, 48'hC0DE_0000_0000 | (48'(p) * 48'h1_0101)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one edge, sample 1 time unit later and score any retirements
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(o_ret_count)) begin
                ent_t e;
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("ret_old_p", 64'(o_ret_old_p[i*6 +: 6]), 64'(e.p));
                    chk("ret_bundle", 64'(o_ret_bundle[i*57 +: 57]), 64'(e.b));
                end
            end else begin
                chk("ret_slot_zero", 64'({o_ret_bundle[i*57 +: 57], o_ret_old_p[i*6 +: 6]}), 64'd0);
            end
        end
    endtask

    task automatic disp(input int n, input bit acc);
        i_ins_count = 3'(n);
        for (int k = 0; k < 4; k++) begin
            logic [5:0] p;
            p = 6'(oid + k);
            i_ins_old_p[k*6 +: 6]   = (k < n) ? p : 6'd0;
            i_ins_bundle[k*57 +: 57] = (k < n) ? bfun(p) : 57'd0;
            if (acc && k < n) sb.push_back('{b: bfun(p), p: p});
        end
        if (acc) begin
            oid    += n;
            tail_m += n;
        end
    endtask

    task automatic cset(input int port, input int idx);
        i_cmpl_en[port]      = 1'b1;
        i_cmpl[port*4 +: 4] = 4'(idx);
    endtask

    task automatic cclr();
        i_cmpl_en = '0;
        i_cmpl    = '0;
    endtask

    // dispatch n, complete them all, expect them to retire together
    task automatic run_group(input int n);
        int a;
        a = tail_m;
        disp(n, 1'b1);
        tick();
        i_ins_count = '0;
        chk("grp_alloc", 64'(o_alloc_idx), 64'(tail_m % 16));
        for (int q = 0; q < n; q++) cset(q, (a + q) % 16);
        tick();
        cclr();
        chk("grp_ret_early", 64'(o_ret_count), 64'd0);
        tick();
        chk("grp_ret_count", 64'(o_ret_count), 64'(n));
        head_m += n;
    endtask

    initial begin
        rst_n        = 1'b0;
        i_flush      = 1'b0;
        i_ins_count  = '0;
        i_ins_bundle = '0;
        i_ins_old_p  = '0;
        cclr();

        // reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_free", 64'(o_free), 64'd16);
        chk("rst_empty", 64'(o_empty), 64'd1);
        chk("rst_alloc", 64'(o_alloc_idx), 64'd0);
        chk("rst_ret_count", 64'(o_ret_count), 64'd0);
        chk("rst_disp_err", 64'(o_disp_err), 64'd0);
        chk("rst_ret_old_p", 64'(o_ret_old_p), 64'd0);
        #3 rst_n = 1'b1;

        // out-of-order completion
        disp(4, 1'b1);
        tick();
        i_ins_count = '0;
        chk("ooo_alloc", 64'(o_alloc_idx), 64'd4);
        chk("ooo_free", 64'(o_free), 64'd12);
        chk("ooo_not_empty", 64'(o_empty), 64'd0);
        cset(0, 2); cset(1, 0);
        tick();
        cclr();
        chk("ooo_ret_none", 64'(o_ret_count), 64'd0);
        tick();
        chk("ooo_ret_one", 64'(o_ret_count), 64'd1);
        chk("ooo_ret_p0", 64'(o_ret_old_p[5:0]), 64'd1);
        chk("ooo_free13", 64'(o_free), 64'd13);
        cset(0, 1); cset(1, 3); cset(2, 3);
        tick();
        cclr();
        chk("ooo_ret_gap", 64'(o_ret_count), 64'd0);
        tick();
        chk("ooo_ret_three", 64'(o_ret_count), 64'd3);
        chk("ooo_empty", 64'(o_empty), 64'd1);
        chk("ooo_free16", 64'(o_free), 64'd16);
        head_m = 4;
        tick();
        chk("ooo_ret_hold", 64'(o_ret_count), 64'd0);

        // advance head to 14, then a group spanning 14,15,0,1
        run_group(4);
        run_group(4);
        run_group(2);
        run_group(4);
        chk("wrap_alloc", 64'(o_alloc_idx), 64'd2);

        // overflow with two free entries
        disp(4, 1'b1); tick();
        disp(4, 1'b1); tick();
        disp(4, 1'b1); tick();
        disp(2, 1'b1); tick();
        i_ins_count = '0;
        chk("ovf_free2", 64'(o_free), 64'd2);
        chk("ovf_alloc", 64'(o_alloc_idx), 64'd0);
        disp(3, 1'b0);
        tick();
        i_ins_count = '0;
        chk("ovf_err", 64'(o_disp_err), 64'd1);
        chk("ovf_free_kept", 64'(o_free), 64'd2);
        chk("ovf_alloc_kept", 64'(o_alloc_idx), 64'd0);
        tick();
        chk("ovf_err_pulse", 64'(o_disp_err), 64'd0);
        disp(2, 1'b1);
        tick();
        i_ins_count = '0;
        chk("ovf_fill", 64'(o_free), 64'd0);
        chk("ovf_fill_alloc", 64'(o_alloc_idx), 64'd2);
        chk("ovf_fill_err", 64'(o_disp_err), 64'd0);

        // full ROB, head done, dispatch while completing head+1
        cset(0, head_m % 16);
        tick();
        cclr();
        chk("full_ret_none", 64'(o_ret_count), 64'd0);
        disp(1, 1'b0);
        cset(0, (head_m + 1) % 16);
        tick();
        i_ins_count = '0;
        cclr();
        chk("full_ret_head", 64'(o_ret_count), 64'd1);
        chk("full_free1", 64'(o_free), 64'd1);
        chk("full_disp_err", 64'(o_disp_err), 64'd1);
        tick();
        chk("full_ret_next", 64'(o_ret_count), 64'd1);
        chk("full_free2", 64'(o_free), 64'd2);
        head_m += 2;

        // drain everything still in flight
        for (int j = head_m; j < tail_m; j += 6) begin
            for (int q = 0; q < 6 && j + q < tail_m; q++) cset(q, (j + q) % 16);
            tick();
            cclr();
        end
        for (int w = 0; w < 20 && !o_empty; w++) tick();
        chk("drain_empty", 64'(o_empty), 64'd1);
        chk("drain_sb", 64'(sb.size()), 64'd0);
        head_m = tail_m;

        // count above DISPATCH_W is rejected even with room
        disp(5, 1'b0);
        tick();
        i_ins_count = '0;
        chk("wide_err", 64'(o_disp_err), 64'd1);
        chk("wide_free", 64'(o_free), 64'd16);
        tick();
        chk("wide_err_pulse", 64'(o_disp_err), 64'd0);

        // completion at the allocating edge targets an invalid entry and is ignored
        cset(0, tail_m % 16);
        disp(1, 1'b1);
        tick();
        i_ins_count = '0;
        cclr();
        tick();
        tick();
        chk("inv_cmpl_ret", 64'(o_ret_count), 64'd0);
        chk("inv_cmpl_busy", 64'(o_empty), 64'd0);
        cset(0, head_m % 16);
        tick();
        cclr();
        tick();
        chk("inv_cmpl_late", 64'(o_ret_count), 64'd1);
        head_m += 1;

`ifdef ROB_FLUSH_EN
        // flush with six in flight, head already done
        disp(4, 1'b1); tick();
        disp(2, 1'b1); tick();
        i_ins_count = '0;
        cset(0, head_m % 16);
        tick();
        cclr();
        i_flush = 1'b1;
        disp(5, 1'b0);
        cset(0, (head_m + 1) % 16);
        tick();
        i_flush = 1'b0;
        i_ins_count = '0;
        cclr();
        sb.delete();
        tail_m = head_m;
        chk("flush_empty", 64'(o_empty), 64'd1);
        chk("flush_ret", 64'(o_ret_count), 64'd0);
        chk("flush_err", 64'(o_disp_err), 64'd0);
        chk("flush_alloc", 64'(o_alloc_idx), 64'(head_m % 16));
        chk("flush_free", 64'(o_free), 64'd16);
        tick();
        chk("flush_ret_after", 64'(o_ret_count), 64'd0);
        chk("flush_still_empty", 64'(o_empty), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
